// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and a window helper shared by
// the generator and its benches.
package vga_timing_pkg;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_BOTTOM  = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_TOP     = 33;
  localparam int VGA_CNT_W     = 10;
  localparam int VGA_FRAME_W   = 8;
  function automatic logic in_win(input int v, input int lo, input int len);
    return v >= lo && v < lo + len;
  endfunction
endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: pixel-enable divider, strobes tick on the last of every CLK_DIV enabled clocks.
module vga_pix_div #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blank flags aligned to hpos/vpos.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_DISPLAY  = VGA_H_DISPLAY,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_DISPLAY  = VGA_V_DISPLAY,
  parameter int V_BOTTOM   = VGA_V_BOTTOM,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_TOP      = VGA_V_TOP,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 1,
  parameter int CNT_W      = VGA_CNT_W,
  parameter int FRAME_W    = VGA_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               hblank,
  output logic               vblank,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_DISPLAY);
  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .tick (pix_tick)
  );
  always_comb begin
    h_wrap = pix_tick && hpos == H_LAST;
    v_wrap = h_wrap && vpos == V_LAST;
    h_nxt  = h_wrap ? '0 : hpos + CNT_W'(pix_tick);
    v_nxt  = v_wrap ? '0 : vpos + CNT_W'(h_wrap);
  end
  // flags are derived from the next counter values so they land in the same cycle as hpos/vpos
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= !H_SYNC_POL;
      vsync       <= !V_SYNC_POL;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= in_win(int'(h_nxt), H_DISPLAY + H_FRONT, H_SYNC) ? H_SYNC_POL : !H_SYNC_POL;
      vsync       <= in_win(int'(v_nxt), V_DISPLAY + V_BOTTOM, V_SYNC) ? V_SYNC_POL : !V_SYNC_POL;
      hblank      <= h_nxt >= H_VIS;
      vblank      <= v_nxt >= V_VIS;
      display_on  <= h_nxt < H_VIS && v_nxt < V_VIS;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      frame_cnt   <= frame_cnt + FRAME_W'(v_wrap);
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: hand vectors plus randomized-enable run against a pixel-index arithmetic model.
module tb_vga_timing_gen;
  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 3, VB = 1, VS = 1, VT = 1;
  localparam int DIV = 3;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int HTOT = HD + HF + HS + HB;
  localparam int VTOT = VD + VB + VS + VT;
  localparam int FRAME_CLK = HTOT * VTOT * DIV;
  typedef struct packed {
    logic [9:0] hp, vp;
    logic hs, vs, don, hb, vb, ls, fs, pt;
    logic [7:0] fc;
  } obs_t;
  typedef struct {
    logic en;
    int   n;
    obs_t exp;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic hsync, vsync, display_on, hblank, vblank, pix_tick, line_start, frame_start;
  logic [9:0] hpos, vpos;
  logic [7:0] frame_cnt;
  int total = 0, bad = 0, e = 0;
  bit wrap_seen = 0;
  vec_t tbl[12];
  always #5 clk = ~clk;
  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .CLK_DIV(DIV), .CNT_W(10), .FRAME_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hblank(hblank), .vblank(vblank), .hpos(hpos), .vpos(vpos),
    .pix_tick(pix_tick), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );
  // ev = enabled clock edges since reset; pixel index is ev/DIV, everything follows from it
  function automatic obs_t model(input int ev, input logic en_v);
    obs_t o;
    int n, h, v;
    n = ev / DIV;
    h = n % HTOT;
    v = (n / HTOT) % VTOT;
    o.hp  = 10'(h);
    o.vp  = 10'(v);
    o.hs  = (h >= HD + HF && h < HD + HF + HS) ? HPOL : !HPOL;
    o.vs  = (v >= VD + VB && v < VD + VB + VS) ? VPOL : !VPOL;
    o.hb  = h >= HD;
    o.vb  = v >= VD;
    o.don = h < HD && v < VD;
    o.ls  = ev > 0 && ev % DIV == 0 && h == 0;
    o.fs  = o.ls && v == 0;
    o.pt  = en_v && ev % DIV == DIV - 1;
    o.fc  = 8'(n / (HTOT * VTOT));
    return o;
  endfunction
  function automatic obs_t mk(input int hp, input int vp, input logic hs, input logic vs,
                              input logic don, input logic hb, input logic vb, input logic ls,
                              input logic fs, input logic pt, input int fc);
    return {10'(hp), 10'(vp), hs, vs, don, hb, vb, ls, fs, pt, 8'(fc)};
  endfunction
  function automatic obs_t act();
    return {hpos, vpos, hsync, vsync, display_on, hblank, vblank, line_start, frame_start,
            pix_tick, frame_cnt};
  endfunction
  task automatic cmp(input string name, input obs_t want);
    obs_t got;
    got = act();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s e=%0d got=%h want=%h", name, e, got, want);
    end
  endtask
  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge clk);
    if (en_v) e++;
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1,  mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1,  mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1'b1, 1,  mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1'b0, 7,  mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b1, 1,  mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1'b1, 11, mk(5, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b1, 6,  mk(7, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 3,  mk(0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0)};
    tbl[8]  = '{1'b1, 1,  mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b1, 71, mk(0, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0)};
    tbl[10] = '{1'b1, 48, mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1)};
    tbl[11] = '{1'b1, 2,  mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1)};
    #12 cmp("reset", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].en);
      cmp($sformatf("vec%0d", i), tbl[i].exp);
    end
    for (int c = 0; c < 60000 && e < 256 * FRAME_CLK + 50; c++) begin
      tick($urandom_range(0, 9) < 8);
      cmp("rand", model(e, en));
      if (frame_start) begin
        total++;
        if (!line_start) begin
          bad++;
          $display("FAIL fs_implies_ls e=%0d line_start=%b required=1", e, line_start);
        end
      end
      if (e == 256 * FRAME_CLK && !wrap_seen) begin
        wrap_seen = 1;
        total++;
        if (frame_cnt !== 8'd0 || frame_start !== 1'b1) begin
          bad++;
          $display("FAIL frame_wrap frame_cnt=%0d fs=%b required 0/1", frame_cnt, frame_start);
        end
      end
    end
    if (!wrap_seen) begin
      total++;
      bad++;
      $display("FAIL frame_wrap not reached e=%0d required %0d", e, 256 * FRAME_CLK);
    end
    for (int k = 0; k < 40; k++) tick(1'b1);
    cmp("pre_rst", model(e, en));
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    e = 0;
    @(posedge clk);
    @(negedge clk);
    cmp("rst_hold", model(0, en));
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick(1'b1);
      cmp("post_rst", model(e, en));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BACK, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines.
- V_BOTTOM, 10, vertical front porch.
- V_SYNC, 2, vsync lines.
- V_TOP, 33, vertical back porch.
- H_SYNC_POL, 0, hsync active level.
- V_SYNC_POL, 0, vsync active level.
- CLK_DIV, 1, clk cycles per pixel (>=1).
- CNT_W, 10, hpos/vpos width.
- FRAME_W, 8, frame counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, timing advance enable.
- hsync, out, 1, horizontal sync at H_SYNC_POL.
- vsync, out, 1, vertical sync at V_SYNC_POL.
- display_on, out, 1, visible region.
- hblank, out, 1, horizontal blanking.
- vblank, out, 1, vertical blanking.
- hpos, out, CNT_W, pixel column.
- vpos, out, CNT_W, line.
- pix_tick, out, 1, pixel advance strobe.
- line_start, out, 1, line wrap pulse.
- frame_start, out, 1, frame wrap pulse.
- frame_cnt, out, FRAME_W, completed frames.

Function
REQ-003 H_TOTAL SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL SHALL be V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP; both SHALL fit in CNT_W bits.
REQ-004 A divider SHALL count 0..CLK_DIV-1 only while en=1; pix_tick SHALL be combinational en && divider==CLK_DIV-1, so it is constant 1 while en=1 when CLK_DIV=1.
REQ-005 On pix_tick, hpos SHALL increment, wrapping from H_TOTAL-1 to 0; vpos SHALL increment only on an hpos wrap, wrapping from V_TOTAL-1 to 0.
REQ-006 With en=0, the counters, divider and all registered outputs SHALL hold their values.
REQ-007 hsync, vsync, display_on, hblank and vblank SHALL be registered, computed from next-state counters, and aligned with the hpos/vpos values in the same cycle (zero relative latency).
REQ-008 hsync SHALL be active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC; vsync SHALL be active iff V_DISPLAY+V_BOTTOM <= vpos < V_DISPLAY+V_BOTTOM+V_SYNC; both SHALL be at their inactive level otherwise.
REQ-009 hblank SHALL be hpos>=H_DISPLAY; vblank SHALL be vpos>=V_DISPLAY; display_on SHALL be !hblank && !vblank.
REQ-010 line_start SHALL be a registered one-clk pulse in the cycle where hpos first equals 0 after a wrap, and SHALL NOT pulse on reset release.
REQ-011 frame_start SHALL pulse in that same cycle only when vpos also wrapped to 0; frame_start therefore implies line_start.
REQ-012 frame_cnt SHALL increment on each frame wrap, wrapping modulo 2^FRAME_W.

Reset
REQ-013 While rst_n=0, asynchronously:
- hpos, vpos, divider and frame_cnt SHALL be 0.
- hsync SHALL be !H_SYNC_POL and vsync SHALL be !V_SYNC_POL.
- hblank, vblank, line_start and frame_start SHALL be 0.
- display_on SHALL be 1.
REQ-014 A reset asserted mid-frame SHALL abandon the frame without producing a frame_start or line_start pulse.

Structure
REQ-015 The default 640x480@60 timing constants SHALL live in a shared package (vga_timing_pkg) for reuse by top-levels and benches.
REQ-016 The pixel-enable divider SHALL be a sub-module, vga_pix_div (parameter CLK_DIV, ports clk, rst_n, en, tick).

Verification
REQ-017 Default parameters, en=1, CLK_DIV=1 -> frame_start period 420000 clk; hsync low for 96 clk per 800; vsync low for 2 lines; display_on high for 640x480 pixels per frame.
REQ-018 H=4/1/2/1, V=3/1/1/1, CLK_DIV=3, H_SYNC_POL=1 -> hpos steps every 3 clk; hsync high exactly while hpos is 5..6; line_start every 24 clk.
REQ-019 Toggle en low for 7 clk mid-line -> all outputs frozen; the sequence resumes with no skipped or repeated hpos.
REQ-020 Assert rst_n=0 at hpos=700, vpos=500 -> all outputs take their REQ-013 values asynchronously; no frame_start is issued on release.
REQ-021 Run 256 frames with FRAME_W=8 -> frame_cnt returns to 0; frame_start coincides with line_start every time.
